// File: rtl/n8_pkg.sv
// Shared definitions for the N8 controller reader: button bit positions and poll FSM states.
// Bit positions follow the order the controller shifts its buttons out.
package n8_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT_A,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

endpackage

// File: rtl/n8_sync.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no flow control.
// RESET_VAL sets the level both flops take during reset.
module n8_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/n8_controller_reader.sv
// Polls an N8 serial controller once per POLL_CYCLES and registers its eight buttons (active high).
// Buttons and valid update one cycle after the DONE state, 17*HALF_CYCLES+1 cycles after latch rises; no backpressure.
module n8_controller_reader
  import n8_pkg::*;
#(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic latch,
  output logic pulse,
  output logic a,
  output logic b,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic valid
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(2 * HALF_CYCLES);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);

  state_t        state, state_n;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] phase;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    btn;
  logic          data_sync;
  logic          start_req;
  logic          sample;

  n8_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data_in),
    .q     (data_sync)
  );

  assign start_req = (poll_cnt == POLL_LAST);

  always_comb begin
    state_n = state;
    sample  = 1'b0;
    case (state)
      IDLE:     if (start_req) state_n = LATCH;
      LATCH:    if (phase == LATCH_LAST) state_n = WAIT_A;
      WAIT_A: begin
        if (phase == HALF_LAST) begin
          state_n = PULSE_HI;
          sample  = 1'b1;
        end
      end
      PULSE_HI: if (phase == HALF_LAST) state_n = PULSE_LO;
      PULSE_LO: begin
        if (phase == HALF_LAST) begin
          state_n = (idx == 3'd7) ? DONE : PULSE_HI;
          sample  = 1'b1;
        end
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      poll_cnt <= '0;
      phase    <= '0;
      idx      <= '0;
      shift    <= '0;
      btn      <= '0;
      latch    <= 1'b0;
      pulse    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      // Free-running poll timer; a wrap seen outside IDLE is simply lost.
      poll_cnt <= start_req ? '0 : poll_cnt + PW'(1);
      state    <= state_n;
      phase    <= (state_n != state || state == IDLE) ? '0 : phase + CW'(1);
      // Strobes are registered from the next state so they are glitch-free and aligned with it.
      latch    <= (state_n == LATCH);
      pulse    <= (state_n == PULSE_HI);
      valid    <= (state == DONE);

      if (sample) begin
        if (state == WAIT_A) begin
          shift[BTN_A] <= ~data_sync;
          idx          <= 3'd1;
        end else begin
          shift[idx] <= ~data_sync;
          idx        <= idx + 3'd1;
        end
      end

      if (state == DONE) btn <= shift;
    end
  end

  assign a      = btn[BTN_A];
  assign b      = btn[BTN_B];
  assign select = btn[BTN_SELECT];
  assign start  = btn[BTN_START];
  assign up     = btn[BTN_UP];
  assign down   = btn[BTN_DOWN];
  assign left   = btn[BTN_LEFT];
  assign right  = btn[BTN_RIGHT];

endmodule

// File: tb/tb_n8_controller_reader.sv
// Bench for n8_controller_reader with a behavioural N8 controller model driving data_in.
module tb_n8_controller_reader;

  localparam int H = 4;
  localparam int P = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b1;
  logic latch, pulse, a, b, select, start, up, down, left, right, valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] btn_vec = 8'h00;
  logic [7:0] model_sh = 8'h00;
  logic       pulse_d = 1'b0;
  bit         glitch = 1'b0;

  n8_controller_reader #(.HALF_CYCLES(H), .POLL_CYCLES(P)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .latch   (latch),
    .pulse   (pulse),
    .a       (a),
    .b       (b),
    .select  (select),
    .start   (start),
    .up      (up),
    .down    (down),
    .left    (left),
    .right   (right),
    .valid   (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller: loads buttons while latch is high, shifts on pulse rise, data active low.
  always @(negedge clk) begin
    if (latch === 1'b1) model_sh = btn_vec;
    else if (pulse === 1'b1 && pulse_d !== 1'b1) model_sh = {1'b0, model_sh[7:1]};
    pulse_d = pulse;
    if (glitch && pulse === 1'b1) data_in = 1'($urandom);
    else data_in = ~model_sh[0];
  end

  // Button vector by name, A in bit 0 through Right in bit 7 (controller shift order).
  function automatic logic [7:0] got();
    return {right, left, down, up, start, select, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a frame and measures its shape; no comparisons here.
  task automatic observe_frame(output int wait_c, output int latch_len, output int npulse,
                               output int bad, output int to_valid, output bit held,
                               output bit tmo);
    logic [7:0] b0;
    int hi, lo;
    logic prev;
    b0 = got();
    wait_c = 0; latch_len = 0; npulse = 0; bad = 0; to_valid = 0; held = 1'b1; tmo = 1'b0;
    hi = 0; lo = 0; prev = 1'b0;
    while (latch !== 1'b1 && wait_c < 3 * P) begin
      tick();
      wait_c++;
      if (got() !== b0 && valid !== 1'b1) held = 1'b0;
    end
    if (latch !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    while (valid !== 1'b1 && to_valid < 4 * P) begin
      if (latch === 1'b1) latch_len++;
      if (pulse === 1'b1) begin
        if (!prev) begin
          npulse++;
          if (npulse > 1 && lo != H) bad++;
        end
        hi++;
        lo = 0;
      end else begin
        if (prev) begin
          if (hi != H) bad++;
          hi = 0;
        end
        lo++;
      end
      if (got() !== b0) held = 1'b0;
      prev = pulse;
      tick();
      to_valid++;
    end
    if (valid !== 1'b1) tmo = 1'b1;
  endtask

  task automatic test_reset();
    int wc, ll, np, bd, tv;
    bit hd, to;
    reset = 1'b1;
    btn_vec = 8'h00;
    repeat (5) tick();
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", latch); end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", pulse); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (got() !== 8'h00) begin errors++; $display("FAIL reset_buttons: got %h expected 00", got()); end
    reset = 1'b0;
    observe_frame(wc, ll, np, bd, tv, hd, to);
    checks++; if (to) begin errors++; $display("FAIL first_frame_timeout: got timeout expected frame"); end
    checks++; if (wc != P) begin errors++; $display("FAIL first_latch_cycle: got %0d expected %0d", wc, P); end
    checks++; if (ll != 2 * H) begin errors++; $display("FAIL latch_width: got %0d expected %0d", ll, 2 * H); end
    checks++; if (np != 7) begin errors++; $display("FAIL pulse_count: got %0d expected 7", np); end
    checks++; if (bd != 0) begin errors++; $display("FAIL pulse_phase_len: got %0d bad phases expected 0", bd); end
    checks++; if (tv != 17 * H + 1) begin errors++; $display("FAIL valid_latency: got %0d expected %0d", tv, 17 * H + 1); end
    checks++; if (got() !== 8'h00) begin errors++; $display("FAIL disconnected_buttons: got %h expected 00", got()); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b expected 0", valid); end
  endtask

  task automatic test_a_right();
    int wc, ll, np, bd, tv;
    bit hd, to;
    btn_vec = 8'b1000_0001;
    observe_frame(wc, ll, np, bd, tv, hd, to);
    checks++; if (to || got() !== 8'h81) begin errors++; $display("FAIL a_right: got %h expected 81 (timeout=%0b)", got(), to); end
    checks++; if ({a, right} !== 2'b11) begin errors++; $display("FAIL a_right_named: got a=%b right=%b expected 1 1", a, right); end
  endtask

  task automatic test_all_then_none();
    int wc, ll, np, bd, tv, v1, v2;
    bit hd, to;
    btn_vec = 8'hFF;
    observe_frame(wc, ll, np, bd, tv, hd, to);
    v1 = cyc;
    checks++; if (!hd) begin errors++; $display("FAIL hold_between_frames: got change before valid expected stable"); end
    checks++; if (to || got() !== 8'hFF) begin errors++; $display("FAIL all_pressed: got %h expected ff", got()); end
    btn_vec = 8'h00;
    observe_frame(wc, ll, np, bd, tv, hd, to);
    v2 = cyc;
    checks++; if (to || got() !== 8'h00) begin errors++; $display("FAIL all_released: got %h expected 00", got()); end
    checks++; if (v2 - v1 != P) begin errors++; $display("FAIL valid_spacing: got %0d expected %0d", v2 - v1, P); end
  endtask

  task automatic test_bit_order();
    int wc, ll, np, bd, tv;
    bit hd, to;
    btn_vec = 8'b0101_1010;
    observe_frame(wc, ll, np, bd, tv, hd, to);
    checks++; if (to || got() !== 8'h5A) begin errors++; $display("FAIL bit_order: got %h expected 5a", got()); end
    checks++; if ({b, start, up, left, a, select, down, right} !== 8'b1111_0000) begin
      errors++; $display("FAIL bit_order_named: got %b expected 11110000", {b, start, up, left, a, select, down, right});
    end
  endtask

  task automatic test_reset_mid_frame();
    int wc, ll, np, bd, tv, n, t;
    bit hd, to;
    logic prev;
    btn_vec = 8'hC3;
    n = 0; t = 0; prev = 1'b0;
    while (n < 3 && t < 3 * P) begin
      tick();
      t++;
      if (pulse === 1'b1 && !prev) n++;
      prev = pulse;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL mid_reset_reach_pulse3: got %0d pulses expected 3", n); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({latch, pulse, valid} !== 3'b000) begin errors++; $display("FAIL mid_reset_strobes: got %b expected 000", {latch, pulse, valid}); end
    checks++; if (got() !== 8'h00) begin errors++; $display("FAIL mid_reset_buttons: got %h expected 00", got()); end
    observe_frame(wc, ll, np, bd, tv, hd, to);
    checks++; if (wc != P) begin errors++; $display("FAIL mid_reset_restart: got %0d expected %0d", wc, P); end
    checks++; if (!hd) begin errors++; $display("FAIL mid_reset_no_update: got button change expected none"); end
    checks++; if (to || got() !== 8'hC3) begin errors++; $display("FAIL mid_reset_next_frame: got %h expected c3", got()); end
  endtask

  task automatic test_random_glitch();
    int wc, ll, np, bd, tv;
    bit hd, to;
    for (int i = 0; i < 6; i++) begin
      glitch = (i % 2) == 0;
      btn_vec = 8'($urandom);
      observe_frame(wc, ll, np, bd, tv, hd, to);
      checks++; if (to || got() !== btn_vec) begin
        errors++; $display("FAIL random_frame%0d: got %h expected %h glitch=%0b", i, got(), btn_vec, glitch);
      end
    end
    glitch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_a_right();
    test_all_then_none();
    test_bit_order();
    test_reset_mid_frame();
    test_random_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
